// File: rtl/led_ctrl_pkg.sv
// Shared types/helpers for the LED pattern demo; LED_CTRL_GRAY_EN adds the GRAY mode.
// No logic of its own: mode encoding, mode count, speed divider and entry patterns.
package led_ctrl_pkg;

`ifdef LED_CTRL_GRAY_EN
    typedef enum logic [2:0] {
        SHIFT_L = 3'd0,
        SHIFT_R = 3'd1,
        BOUNCE  = 3'd2,
        BLINK   = 3'd3,
        GRAY    = 3'd4
    } mode_t;
    localparam int NUM_MODES = 5;
`else
    typedef enum logic [2:0] {
        SHIFT_L = 3'd0,
        SHIFT_R = 3'd1,
        BOUNCE  = 3'd2,
        BLINK   = 3'd3
    } mode_t;
    localparam int NUM_MODES = 4;
`endif

    localparam mode_t LAST_MODE = mode_t'(3'(NUM_MODES - 1));

    // Each speed step halves the tick rate, so the period doubles.
    function automatic logic [31:0] speed_div(input logic [31:0] base, input logic [1:0] spd);
        return ((base + 32'd1) << spd) - 32'd1;
    endfunction

    function automatic logic [31:0] entry_pattern(input mode_t m, input int unsigned w);
        case (m)
            SHIFT_R: return 32'd1 << (w - 1);
            BLINK:   return ~(32'hFFFF_FFFF << w);
`ifdef LED_CTRL_GRAY_EN
            GRAY:    return 32'd0;
`endif
            default: return 32'd1;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_tick_gen.sv
// Programmable tick enable: counts 0..div, pulses a registered tick on the wrap edge.
// Latency: tick is high in the cycle after counter == div. pause holds the count; clear restarts it.
module tick_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] div,
    input  logic        pause,
    input  logic        clear,
    output logic        wrap,
    output logic        tick
);

    logic [31:0] cnt;

    assign wrap = !pause && !clear && (cnt == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 32'd0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= 32'd0;
            tick <= 1'b0;
        end else if (pause) begin
            tick <= 1'b0;
        end else if (wrap) begin
            cnt  <= 32'd0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 32'd1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: mode FSM, pattern registers and speed latch over tick_gen; LED_CTRL_GRAY_EN adds GRAY.
// Latency: led/tick/mode registered, one step per tick. pause freezes counter and LEDs; next_mode still honoured.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int LED_W    = 4,
    parameter int BASE_DIV = 15_624_999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             next_mode,
    input  logic             pause,
    input  logic [1:0]       speed_sel,
    output logic [LED_W-1:0] led,
    output logic             tick,
    output logic [2:0]       mode
);

    mode_t             mode_q;
    mode_t             mode_nxt;
    logic [1:0]        cur_speed;
    logic [31:0]       cur_div;
    logic              wrap;
    logic              bounce_up;
    logic              bounce_up_step;
    logic [LED_W-1:0]  led_step;
    logic [LED_W-1:0]  led_entry;

    assign cur_div   = speed_div(32'(BASE_DIV), cur_speed);
    assign mode_nxt  = (mode_q == LAST_MODE) ? SHIFT_L : mode_t'(mode_q + 3'd1);
    assign led_entry = LED_W'(entry_pattern(mode_nxt, LED_W));

    tick_gen u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .div   (cur_div),
        .pause (pause),
        .clear (next_mode),
        .wrap  (wrap),
        .tick  (tick)
    );

`ifdef LED_CTRL_GRAY_EN
    logic [LED_W-1:0] gray_b;
    logic [LED_W-1:0] gray_nxt;
    assign gray_nxt = gray_b + LED_W'(1);
    assign mode     = mode_q;
`else
    assign mode     = {1'b0, mode_q[1:0]};
`endif

    always_comb begin
        led_step       = led;
        bounce_up_step = bounce_up;
        case (mode_q)
            SHIFT_L: led_step = {led[LED_W-2:0], led[LED_W-1]};
            SHIFT_R: led_step = {led[0], led[LED_W-1:1]};
            BOUNCE: begin
                // Direction flips on the step that lands on an end bit.
                if (bounce_up) begin
                    led_step = led << 1;
                    if (led_step[LED_W-1]) bounce_up_step = 1'b0;
                end else begin
                    led_step = led >> 1;
                    if (led_step[0]) bounce_up_step = 1'b1;
                end
            end
            BLINK:   led_step = ~led;
`ifdef LED_CTRL_GRAY_EN
            GRAY:    led_step = gray_nxt ^ (gray_nxt >> 1);
`endif
            default: led_step = led;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= SHIFT_L;
            led       <= LED_W'(1);
            bounce_up <= 1'b1;
            cur_speed <= 2'd0;
`ifdef LED_CTRL_GRAY_EN
            gray_b    <= '0;
`endif
        end else if (next_mode) begin
            mode_q    <= mode_nxt;
            led       <= led_entry;
            bounce_up <= 1'b1;
            cur_speed <= speed_sel;
`ifdef LED_CTRL_GRAY_EN
            gray_b    <= '0;
`endif
        end else if (wrap) begin
            led       <= led_step;
            bounce_up <= bounce_up_step;
            cur_speed <= speed_sel;
`ifdef LED_CTRL_GRAY_EN
            if (mode_q == GRAY) gray_b <= gray_nxt;
`endif
        end
    end

endmodule
